// File: rtl/cmd_dispatch.sv
// cmd_dispatch: one-at-a-time command dispatcher to N_TGT executors with
// fixed-latency response capture and saturating command/error counters.
module cmd_dispatch #(
    parameter int N_TGT   = 4,
    parameter int RSP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_vld,
    input  logic [31:0]          cmd,
    output logic                 cmd_rdy,
    output logic [31:0]          cmd_out,
    output logic [N_TGT-1:0]     run,
    input  logic [32*N_TGT-1:0]  rsp_bus,
    output logic                 rsp_vld,
    output logic [31:0]          rsp,
    input  logic                 rsp_rdy,
    output logic                 busy,
    output logic [15:0]          n_cmd,
    output logic [15:0]          n_err
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT,
        ERR,
        RESP
    } state_t;

    localparam logic [4:0] NTGT_W = 5'(N_TGT);
    localparam logic [3:0] LAT_W  = 4'(RSP_LAT);

    state_t      state_q, state_d;
    logic [31:0] cmd_out_q, cmd_out_d;
    logic [31:0] rsp_q, rsp_d;
    logic [15:0] n_cmd_q, n_cmd_d;
    logic [15:0] n_err_q, n_err_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  tgt;
    logic [31:0] rsp_sel;
    logic        accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign tgt     = cmd_out_q[31:28];
    assign cmd_rdy = (state_q == IDLE) && !rst;
    assign busy    = (state_q != IDLE) && !rst;
    assign rsp_vld = (state_q == RESP) && !rst;
    assign accept  = cmd_vld && cmd_rdy;
    assign cmd_out = cmd_out_q;
    assign rsp     = rsp_q;
    assign n_cmd   = n_cmd_q;
    assign n_err   = n_err_q;

    always_comb begin
        rsp_sel = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (tgt == 4'(i)) rsp_sel = rsp_bus[32*i +: 32];
        end
    end

    // RUN is only entered with an in-range target, so this stays one-hot
    always_comb begin
        run = '0;
        if (state_q == RUN && !rst) begin
            for (int i = 0; i < N_TGT; i++) begin
                run[i] = (tgt == 4'(i));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_out_d = cmd_out_q;
        rsp_d     = rsp_q;
        n_cmd_d   = n_cmd_q;
        n_err_d   = n_err_q;
        wait_d    = wait_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_out_d = cmd;
                    n_cmd_d   = sat_inc(n_cmd_q);
                    if ({1'b0, cmd[31:28]} < NTGT_W) begin
                        state_d = RUN;
                    end else begin
                        state_d = ERR;
                        n_err_d = sat_inc(n_err_q);
                    end
                end
            end
            RUN: begin
                state_d = WAIT;
                wait_d  = LAT_W;
            end
            WAIT: begin
                if (wait_q == 4'd1) begin
                    rsp_d   = rsp_sel;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ERR: begin
                rsp_d   = {4'hF, cmd_out_q[27:0]};
                state_d = RESP;
            end
            RESP: begin
                if (rsp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_out_q <= '0;
            rsp_q     <= '0;
            n_cmd_q   <= '0;
            n_err_q   <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_out_q <= cmd_out_d;
            rsp_q     <= rsp_d;
            n_cmd_q   <= n_cmd_d;
            n_err_q   <= n_err_d;
            wait_q    <= wait_d;
        end
    end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameter N_TGT, default 4: number of command executors; legal range 1..15.
REQ-002 Parameter RSP_LAT, default 1: cycles from the executor run pulse to a valid executor rsp; legal range 1..15.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cmd_vld  in  1  upstream command valid.
REQ-006 cmd  in  32  command word: [31:28] target, [27:24] instr, [23:0] data.
REQ-007 cmd_rdy  out  1  dispatcher can accept a command.
REQ-008 cmd_out  out  32  registered copy of the accepted command, broadcast to all executors.
REQ-009 run  out  N_TGT  one-hot single-cycle executor run strobe; bit i corresponds to target code i.
REQ-010 rsp_bus  in  32*N_TGT  executor responses; slice [32i+31:32i] belongs to target i.
REQ-011 rsp_vld  out  1  response valid to upstream.
REQ-012 rsp  out  32  response word.
REQ-013 rsp_rdy  in  1  upstream accepts the response.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 n_cmd  out  16  count of accepted commands; saturates at 0xFFFF.
REQ-016 n_err  out  16  count of bad-target commands; saturates at 0xFFFF.

Function
REQ-017 FSM states: IDLE, RUN, WAIT, ERR, RESP.
REQ-018 IDLE: cmd_rdy=1; all other states: cmd_rdy=0; only one command is in flight.
REQ-019 Accept = cmd_vld && cmd_rdy; on accept, cmd_out <= cmd and n_cmd increments.
REQ-020 On accept with target < N_TGT: next state RUN.
REQ-021 On accept with target >= N_TGT: next state ERR; n_err increments.
REQ-022 RUN lasts exactly one cycle; run[target]=1 and every other run bit is 0; next state WAIT with the wait counter loaded to RSP_LAT.
REQ-023 run is 0 in every state other than RUN.
REQ-024 WAIT lasts exactly RSP_LAT cycles.
REQ-025 On the final WAIT cycle: rsp <= rsp_bus slice[target], then go to RESP.
REQ-026 ERR lasts one cycle: rsp <= {4'hF, cmd_out[27:0]}, then go to RESP.
REQ-027 RESP: rsp_vld=1 and rsp is held stable; on rsp_rdy=1, go to IDLE; rsp_vld=0 in all other states.
REQ-028 A response handshake and a new command accept never occur in the same cycle; the earliest next accept is the cycle after the RESP handshake.
REQ-029 Valid-target latency: accept at edge 0 -> run high in cycle 1 -> rsp_vld high from cycle 2+RSP_LAT.
REQ-030 Bad-target latency: accept at edge 0 -> rsp_vld high from cycle 2.
REQ-031 cmd_out is held from accept until the next accept, so executors see a stable cmd during run and WAIT.
REQ-032 Target code 0xF is never valid, so error responses are always distinguishable by rsp[31:28]=4'hF.
REQ-033 cmd_vld while not in IDLE is ignored; the command is not consumed and upstream must hold it.
REQ-034 Counter saturation: at 0xFFFF, a further increment leaves the value unchanged.

Reset
REQ-035 While rst=1 at a clock edge: state <= IDLE; cmd_out, rsp, n_cmd, n_err <= 0.
REQ-036 run, rsp_vld and busy are 0 during reset; cmd_rdy is 0 while rst=1 and 1 in the first cycle after rst falls.
REQ-037 Reset in any state aborts the operation: the pending response is discarded and counters clear.

Verification
REQ-038 Reset release, cmd_vld=1, cmd=0x1200_0ABC, N_TGT=4, RSP_LAT=1, rsp_bus slice1=0x0000_0ABC -> run=4'b0010 for one cycle, rsp_vld with rsp=0x0000_0ABC at cycle 3, n_cmd=1.
REQ-039 cmd=0x7000_0001 with N_TGT=4 -> no run pulse; rsp=0xF000_0001 at cycle 2; n_err=1, n_cmd=1.
REQ-040 Hold rsp_rdy=0 for 10 cycles in RESP -> rsp_vld and rsp stable; cmd_rdy=0 throughout; a second cmd_vld is not accepted until the cycle after rsp_rdy=1.
REQ-041 RSP_LAT=3, cmd=0x0100_3FFF -> run[0] in cycle 1; rsp sampled from rsp_bus slice0 on the third WAIT cycle; rsp_vld at cycle 5.
REQ-042 Assert rst during WAIT -> no rsp_vld; run=0; n_cmd=0; the next command after reset completes normally.
REQ-043 Preload by issuing 65536 bad-target commands, then issue one more -> n_err=0xFFFF and n_cmd=0xFFFF, no wrap to 0.
